// File: rtl/vc_fifo_pkg.sv
// Shared defaults, select-width helper and count type for the virtual-channel FIFO bank.
// Pure declarations; no logic, no latency, no backpressure.
package vc_fifo_pkg;

    localparam int DEF_NUM_VC     = 2;
    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef logic [DEF_ADDR_WIDTH:0] cnt_t;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// One virtual-channel FIFO: storage, pointers, count, threshold flags and sticky error bit.
// Read data is combinational from rd_ptr; a full lane accepts a write only alongside an accepted read.
module vc_fifo_lane
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  i_wr_sel,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic                  i_rd_sel,
    input  logic                  i_err_clr,
    input  logic [ADDR_WIDTH-1:0] i_umbral_empty,
    input  logic [ADDR_WIDTH-1:0] i_umbral_full,
    output logic                  o_rd_acc,
    output logic [DATA_WIDTH-1:0] o_rd_dat,
    output logic [ADDR_WIDTH:0]   o_cnt,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_error;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_new_err;
    logic [ADDR_WIDTH:0]   w_af_lvl;

    // Read is judged on the pre-edge count; a full lane frees a slot only if it is read this cycle.
    assign w_rd_acc  = i_rd_sel && (r_cnt != '0);
    assign w_wr_acc  = i_wr_sel && ((r_cnt != DEPTH_C) || w_rd_acc);
    assign w_new_err = (i_wr_sel && !w_wr_acc) || (i_rd_sel && !w_rd_acc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_error  <= 1'b0;
        end else if (init) begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_wr_acc && !w_rd_acc)
                r_cnt <= r_cnt + CNT_ONE;
            else if (w_rd_acc && !w_wr_acc)
                r_cnt <= r_cnt - CNT_ONE;
            if (w_new_err)
                r_error <= 1'b1;
            else if (i_err_clr)
                r_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    assign w_af_lvl       = DEPTH_C - {1'b0, i_umbral_full};
    assign o_rd_acc       = w_rd_acc;
    assign o_rd_dat       = r_mem[r_rd_ptr];
    assign o_cnt          = r_cnt;
    assign o_empty        = (r_cnt == '0);
    assign o_full         = (r_cnt == DEPTH_C);
    assign o_almost_empty = (r_cnt != '0) && (r_cnt <= {1'b0, i_umbral_empty});
    assign o_almost_full  = (r_cnt != DEPTH_C) && (r_cnt >= w_af_lvl);
    assign o_error        = r_error;

endmodule

// File: rtl/vc_fifo_bank.sv
// NUM_VC virtual-channel FIFOs behind shared write/read ports; read data registered, 1-clock latency.
// Rejected requests never stall; they set the VC's sticky error. VC_FIFO_OCC_OUT_EN adds the occupancy port.
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int   NUM_VC     = DEF_NUM_VC,
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int   ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int  VC_SEL_W   = sel_width(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  wr_enable,
    input  logic [VC_SEL_W-1:0]   wr_vc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [VC_SEL_W-1:0]   rd_vc,
    input  logic [ADDR_WIDTH-1:0] umbral_empty,
    input  logic [ADDR_WIDTH-1:0] umbral_full,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [NUM_VC-1:0]     full,
    output logic [NUM_VC-1:0]     empty,
    output logic [NUM_VC-1:0]     almost_full,
    output logic [NUM_VC-1:0]     almost_empty,
    output logic [NUM_VC-1:0]     error
`ifdef VC_FIFO_OCC_OUT_EN
    ,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] occupancy
`endif
);

    logic [NUM_VC-1:0]     w_wr_sel;
    logic [NUM_VC-1:0]     w_rd_sel;
    logic [NUM_VC-1:0]     w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_dat [NUM_VC];
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic                  w_err_clr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
`ifdef VC_FIFO_OCC_OUT_EN
    logic [ADDR_WIDTH:0]   w_cnt [NUM_VC];
`endif

    // Out-of-range selects decode to no lane, so they are dropped without flagging an error.
    always_comb begin
        w_wr_sel = '0;
        w_rd_sel = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_wr_sel[v] = reset && init && wr_enable && (wr_vc == VC_SEL_W'(v));
            w_rd_sel[v] = reset && init && rd_enable && (rd_vc == VC_SEL_W'(v));
        end
    end

    assign w_err_clr = init && err_clear;

    always_comb begin
        w_rd_mux = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_rd_acc[v]) w_rd_mux = w_rd_dat[v];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_lane
            vc_fifo_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_lane (
                .clk            (clk),
                .reset          (reset),
                .init           (init),
                .i_wr_sel       (w_wr_sel[g]),
                .i_wr_dat       (data_in),
                .i_rd_sel       (w_rd_sel[g]),
                .i_err_clr      (w_err_clr),
                .i_umbral_empty (umbral_empty),
                .i_umbral_full  (umbral_full),
                .o_rd_acc       (w_rd_acc[g]),
                .o_rd_dat       (w_rd_dat[g]),
`ifdef VC_FIFO_OCC_OUT_EN
                .o_cnt          (w_cnt[g]),
`else
                .o_cnt          (),
`endif
                .o_full         (full[g]),
                .o_empty        (empty[g]),
                .o_almost_full  (almost_full[g]),
                .o_almost_empty (almost_empty[g]),
                .o_error        (error[g])
            );
`ifdef VC_FIFO_OCC_OUT_EN
            assign occupancy[g*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)] = reset ? w_cnt[g] : '0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (|w_rd_acc) begin
            r_data_out   <= w_rd_mux;
            r_data_valid <= 1'b1;
        end else begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank (2 VCs, depth 16, 6-bit data) with a queue model and read scoreboard.
module tb_vc_fifo_bank;

    logic       clk;
    logic       reset;
    logic       init;
    logic       wr_enable;
    logic [0:0] wr_vc;
    logic [5:0] data_in;
    logic       rd_enable;
    logic [0:0] rd_vc;
    logic [3:0] umbral_empty;
    logic [3:0] umbral_full;
    logic       err_clear;
    logic [5:0] data_out;
    logic       data_valid;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] almost_full;
    logic [1:0] almost_empty;
    logic [1:0] error;
`ifdef VC_FIFO_OCC_OUT_EN
    logic [9:0] occupancy;
`endif

    vc_fifo_bank dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .wr_enable    (wr_enable),
        .wr_vc        (wr_vc),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .rd_vc        (rd_vc),
        .umbral_empty (umbral_empty),
        .umbral_full  (umbral_full),
        .err_clear    (err_clear),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef VC_FIFO_OCC_OUT_EN
        .occupancy    (occupancy),
`endif
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] mq [2][$];
    logic [5:0] sb [$];
    logic [1:0] err_m = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic wv, input logic [5:0] wd,
                        input logic re, input logic rv, input logic clr);
        logic       ra;
        logic       wa;
        logic [5:0] d;
        logic [1:0] ee, ef, eae, eaf;
        int         n;
        int         ue;
        int         uf;
        ra = 1'b0;
        wa = 1'b0;
        wr_enable = we; wr_vc = wv; data_in = wd;
        rd_enable = re; rd_vc = rv; err_clear = clr;
        if (!reset) begin
            mq[0].delete(); mq[1].delete(); sb.delete();
            err_m = 2'b00;
        end else if (init) begin
            ra = re && (mq[rv].size() > 0);
            wa = we && ((mq[wv].size() < 16) || (ra && (rv == wv)));
            if (clr) err_m = 2'b00;
            if (we && !wa) err_m[wv] = 1'b1;
            if (re && !ra) err_m[rv] = 1'b1;
            if (ra) begin
                d = mq[rv].pop_front();
                sb.push_back(d);
            end
            if (wa) mq[wv].push_back(wd);
        end
        @(posedge clk);
        #1;
        chk("data_valid", {31'b0, data_valid}, {31'b0, ra});
        if (ra) chk("data_out", {26'b0, data_out}, {26'b0, sb.pop_front()});
        else    chk("data_out_idle", {26'b0, data_out}, 32'd0);
        ue = int'(umbral_empty);
        uf = int'(umbral_full);
        for (int v = 0; v < 2; v++) begin
            n      = mq[v].size();
            ee[v]  = (n == 0);
            ef[v]  = (n == 16);
            eae[v] = (n != 0) && (n <= ue);
            eaf[v] = (n != 16) && (n >= 16 - uf);
        end
        chk("empty", {30'b0, empty}, {30'b0, ee});
        chk("full", {30'b0, full}, {30'b0, ef});
        chk("almost_empty", {30'b0, almost_empty}, {30'b0, eae});
        chk("almost_full", {30'b0, almost_full}, {30'b0, eaf});
        chk("error", {30'b0, error}, {30'b0, err_m});
`ifdef VC_FIFO_OCC_OUT_EN
        chk("occ0", {27'b0, occupancy[4:0]}, mq[0].size());
        chk("occ1", {27'b0, occupancy[9:5]}, mq[1].size());
`endif
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init = 1'b0;
        wr_enable = 1'b0; wr_vc = '0; data_in = '0;
        rd_enable = 1'b0; rd_vc = '0; err_clear = 1'b0;
        umbral_empty = 4'd0; umbral_full = 4'd0;

        // Reset state, with a write request that reset must override
        step(1'b1, 1'b0, 6'h05, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; init = 1'b1;

        // Fill VC0 with 0x01..0x10, then drain it in order
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 6'(i + 1), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);

        // Refill VC0, overflow it, then clear the error
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 6'(i + 17), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 6'h3F, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);

        // Underflow VC1; then clear coinciding with a fresh VC1 error keeps it set
        step(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);

        // Full VC0: simultaneous write and read both succeed
        step(1'b1, 1'b0, 6'h2A, 1'b1, 1'b0, 1'b0);

        // Thresholds; fill VC1 while draining VC0 in the same cycles
        umbral_empty = 4'd3; umbral_full = 4'd4;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 6'(48 + i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);

        // init low: requests ignored, state holds
        init = 1'b0;
        step(1'b1, 1'b0, 6'h15, 1'b1, 1'b1, 1'b1);
        init = 1'b1;
        step(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1);

        // Reset mid-burst
        reset = 1'b0;
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i + 2), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 6'(i + 9), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 6'h22, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
Bank of NUM_VC independent virtual-channel FIFOs behind one shared write port and one shared read port, each port with its own VC select. It sits in the PCIe transmit-layer datapath between the packet classifier and the VC arbiter. It generalises the single-VC FIFO with:
- parametrised channel count
- overflow/underflow protection
- sticky per-VC error flags
- range-based almost flags
- a read-valid strobe

Parameters:
NUM_VC, 2, number of virtual channels (1..8)
DATA_WIDTH, 6, payload width in bits
ADDR_WIDTH, 4, log2 of per-VC depth; DEPTH = 2**ADDR_WIDTH
VC_SEL_W, $clog2(NUM_VC) (min 1), width of VC select fields (derived; do not override)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
init  input  1  enable; when 0, all state holds
wr_enable  input  1  write request
wr_vc  input  VC_SEL_W  target VC for write
data_in  input  DATA_WIDTH  write data
rd_enable  input  1  read request
rd_vc  input  VC_SEL_W  source VC for read
umbral_empty  input  ADDR_WIDTH  almost-empty threshold, shared by all VCs
umbral_full  input  ADDR_WIDTH  almost-full threshold, shared by all VCs
err_clear  input  1  clears all sticky error bits
data_out  output  DATA_WIDTH  registered read data
data_valid  output  1  data_out holds a popped word this cycle
full  output  NUM_VC  per-VC full flag
empty  output  NUM_VC  per-VC empty flag
almost_full  output  NUM_VC  per-VC almost-full flag
almost_empty  output  NUM_VC  per-VC almost-empty flag
error  output  NUM_VC  per-VC sticky overflow/underflow flag

Behaviour:
- Reset (reset==0 at clk edge):
  - all pointers and counts go to 0; memory contents need not be cleared
  - data_out=0, data_valid=0, error=0
  - status flags: empty=all 1s; full, almost_full, almost_empty all 0
  - reset wins over every other input, including mid-burst.
- init==0 (reset==1): pointers, counts, memory and error hold; data_valid=0; data_out=0.
- Per-VC count cnt[v] is ADDR_WIDTH+1 bits, range 0..DEPTH; it never exceeds DEPTH.
- Write, when reset==1 and init==1 and wr_enable==1:
  - Accepted if cnt[wr_vc]<DEPTH, or if a read of the same VC is accepted in the same cycle.
  - On accept: mem[wr_vc][wr_ptr] <= data_in; wr_ptr wraps modulo DEPTH.
  - On reject: no state change except error[wr_vc] <= 1.
- Read, when reset==1 and init==1 and rd_enable==1:
  - Accepted if cnt[rd_vc]>0, judged on the pre-edge count. There is no write-to-read bypass.
  - On accept: next cycle data_out=mem[rd_vc][rd_ptr] and data_valid=1; rd_ptr wraps. Latency is 1 clock.
  - On reject: data_valid=0, data_out=0, error[rd_vc] <= 1.
  - When not reading: data_valid=0, data_out=0.
- Count update per VC: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither occur.
- Writes and reads to different VCs in the same cycle are fully independent.
- Flags are combinational from cnt:
  - empty = (cnt==0)
  - full = (cnt==DEPTH)
  - almost_empty = (cnt!=0) && (cnt<=umbral_empty)
  - almost_full = (cnt!=DEPTH) && (cnt>=DEPTH-umbral_full)
  - a threshold of 0 disables the corresponding almost flag.
- error is sticky; it clears only on reset or on err_clear==1 (with init==1). If a new error and err_clear occur in the same cycle, the new error wins.
- wr_vc or rd_vc >= NUM_VC: request is rejected and no error bit is set.

Optional Feature:
VC_FIFO_OCC_OUT_EN
- Defined: adds output port occupancy, width NUM_VC*(ADDR_WIDTH+1), carrying cnt[v] at slice v. It reads 0 under reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vc_fifo_pkg holds:
  - default DATA_WIDTH, ADDR_WIDTH and NUM_VC localparams
  - the sel_width function (clog2, min 1)
  - a typedef for the count width.
- Sub-module vc_fifo_lane: one VC, containing memory, pointers, count, flags and the error bit.
  - It is instantiated NUM_VC times via generate.
  - vc_fifo_bank itself holds the wr/rd VC decode, the read mux and the output register.

Test Plan:
1. Reset then init=1; write 0x01..0x10 to VC0 (16 writes) -> full[0]=1 after the 16th write, empty[1]=1; read 16 from VC0 -> data_out 0x01..0x10, each 1 cycle after its rd_enable, data_valid high each cycle.
2. VC0 full, 17th write 0x3F with no read -> rejected, error[0]=1, count stays 16; err_clear pulse -> error[0]=0.
3. VC1 empty, rd_enable with rd_vc=1 -> data_valid=0, data_out=0, error[1]=1; VC0 unaffected.
4. VC0 full, simultaneous write 0x2A and read of VC0 -> write accepted, full[0] stays 1, 0x2A emerges after the 15 remaining older words.
5. umbral_empty=3, umbral_full=4; fill VC1 to 3 -> almost_empty[1]=1; fill to 12 -> almost_full[1]=1; fill to 16 -> almost_full[1]=0, full[1]=1.
6. Write 5 words to VC0 and 2 to VC1, then assert reset low for one edge mid-burst -> all counts 0, empty=2'b11, error=0, data_valid=0; subsequent reads return nothing and set error.
